// File: rtl/doraemon_pkg.sv
// ---------------------------------------------------------------------------
// doraemon_pkg
// Shared types for the door selector: FSM state encoding, score width helper
// and the candidate record layout (default widths) used around the selector.
// No ports.
// ---------------------------------------------------------------------------
package doraemon_pkg;

    // Selector FSM states
    typedef enum logic [2:0] {
        FILL   = 3'd0,
        EVAL   = 3'd1,
        OUT    = 3'd2,
        REFILL = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int unsigned DEF_ID_W   = 5;
    localparam int unsigned DEF_ATTR_W = 8;
    localparam int unsigned DEF_WGT_W  = 3;

    // Three ATTR_W x WGT_W products summed need two extra bits to never overflow
    function automatic int unsigned score_w(input int unsigned attr_w,
                                            input int unsigned wgt_w);
        return attr_w + wgt_w + 2;
    endfunction

    // Candidate record at default widths
    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_ATTR_W-1:0] size;
        logic [DEF_ATTR_W-1:0] iq;
        logic [DEF_ATTR_W-1:0] eq;
    } rec_t;

endpackage

// File: rtl/doraemon_score.sv
// ---------------------------------------------------------------------------
// doraemon_score
// Combinational weighted score: size*wsize + iq*wiq + eq*weq, unsigned, at
// full width (no truncation or saturation).
// Ports:
//   size, iq, eq        in  ATTR_W   attributes
//   wsize, wiq, weq     in  WGT_W    weights
//   score_c             out SCORE_W  weighted sum (combinational)
// ---------------------------------------------------------------------------
module doraemon_score
    import doraemon_pkg::*;
#(
    parameter int unsigned ATTR_W = 8,
    parameter int unsigned WGT_W  = 3
) (
    input  logic [ATTR_W-1:0]                    size,
    input  logic [ATTR_W-1:0]                    iq,
    input  logic [ATTR_W-1:0]                    eq,
    input  logic [WGT_W-1:0]                     wsize,
    input  logic [WGT_W-1:0]                     wiq,
    input  logic [WGT_W-1:0]                     weq,
    output logic [score_w(ATTR_W, WGT_W)-1:0]    score_c
);

    localparam int unsigned SCORE_W = score_w(ATTR_W, WGT_W);

    logic [SCORE_W-1:0] p_size;
    logic [SCORE_W-1:0] p_iq;
    logic [SCORE_W-1:0] p_eq;

    // Products widened before multiplying so the sum cannot wrap
    always_comb begin
        p_size  = SCORE_W'(size) * SCORE_W'(wsize);
        p_iq    = SCORE_W'(iq)   * SCORE_W'(wiq);
        p_eq    = SCORE_W'(eq)   * SCORE_W'(weq);
        score_c = p_size + p_iq + p_eq;
    end

endmodule

// File: rtl/doraemon_selector.sv
// ---------------------------------------------------------------------------
// doraemon_selector
// Holds N_DOOR candidate records, scores them one per cycle with a shared
// scorer, reports the best slot (max or min mode), then refills only the
// winning slot. Stops after TOTAL selections.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               input record handshake
//   in_id, in_size, in_iq, in_eq    record fields
//   in_wsize, in_wiq, in_weq        weights (latched with last fill / refill)
//   in_min                          1 = pick lowest score
//   out_valid/out_ready             result handshake
//   out_door, out_id, out_score     winning slot, its ID and score
//   done                            TOTAL selections completed
// ---------------------------------------------------------------------------
module doraemon_selector
    import doraemon_pkg::*;
#(
    parameter int unsigned N_DOOR = 5,
    parameter int unsigned ID_W   = 5,
    parameter int unsigned ATTR_W = 8,
    parameter int unsigned WGT_W  = 3,
    parameter int unsigned TOTAL  = 6000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ID_W-1:0]                      in_id,
    input  logic [ATTR_W-1:0]                    in_size,
    input  logic [ATTR_W-1:0]                    in_iq,
    input  logic [ATTR_W-1:0]                    in_eq,
    input  logic [WGT_W-1:0]                     in_wsize,
    input  logic [WGT_W-1:0]                     in_wiq,
    input  logic [WGT_W-1:0]                     in_weq,
    input  logic                                 in_min,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(N_DOOR)-1:0]            out_door,
    output logic [ID_W-1:0]                      out_id,
    output logic [score_w(ATTR_W, WGT_W)-1:0]    out_score,
    output logic                                 done
);

    localparam int unsigned DOOR_W  = $clog2(N_DOOR);
    localparam int unsigned SCORE_W = score_w(ATTR_W, WGT_W);
    localparam int unsigned CNT_W   = $clog2(TOTAL + 1);
    localparam logic [DOOR_W-1:0] LAST_K = DOOR_W'(N_DOOR - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TOTAL);

    state_e              state_q, state_d;

    logic [ID_W-1:0]     slot_id_q   [N_DOOR];
    logic [ID_W-1:0]     slot_id_d   [N_DOOR];
    logic [ATTR_W-1:0]   slot_size_q [N_DOOR];
    logic [ATTR_W-1:0]   slot_size_d [N_DOOR];
    logic [ATTR_W-1:0]   slot_iq_q   [N_DOOR];
    logic [ATTR_W-1:0]   slot_iq_d   [N_DOOR];
    logic [ATTR_W-1:0]   slot_eq_q   [N_DOOR];
    logic [ATTR_W-1:0]   slot_eq_d   [N_DOOR];

    logic [WGT_W-1:0]    wsize_q, wsize_d;
    logic [WGT_W-1:0]    wiq_q, wiq_d;
    logic [WGT_W-1:0]    weq_q, weq_d;
    logic                min_q, min_d;

    logic [DOOR_W-1:0]   fill_idx_q, fill_idx_d;
    logic [DOOR_W-1:0]   k_q, k_d;
    logic [DOOR_W-1:0]   best_idx_q, best_idx_d;
    logic [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [DOOR_W-1:0]   out_door_q, out_door_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic [SCORE_W-1:0]  out_score_q, out_score_d;
    logic                done_q, done_d;

    logic                accept;
    logic                wr_en;
    logic                wgt_en;
    logic [DOOR_W-1:0]   wr_idx;
    logic                better;
    logic [SCORE_W-1:0]  score_c;

    // Single scorer, time-multiplexed over slot index k
    doraemon_score #(
        .ATTR_W (ATTR_W),
        .WGT_W  (WGT_W)
    ) u_score (
        .size    (slot_size_q[k_q]),
        .iq      (slot_iq_q[k_q]),
        .eq      (slot_eq_q[k_q]),
        .wsize   (wsize_q),
        .wiq     (wiq_q),
        .weq     (weq_q),
        .score_c (score_c)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d      = state_q;
        slot_id_d    = slot_id_q;
        slot_size_d  = slot_size_q;
        slot_iq_d    = slot_iq_q;
        slot_eq_d    = slot_eq_q;
        wsize_d      = wsize_q;
        wiq_d        = wiq_q;
        weq_d        = weq_q;
        min_d        = min_q;
        fill_idx_d   = fill_idx_q;
        k_d          = k_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_door_d   = out_door_q;
        out_id_d     = out_id_q;
        out_score_d  = out_score_q;
        wr_en        = 1'b0;
        wgt_en       = 1'b0;
        wr_idx       = fill_idx_q;

        // in_ready_q is only high in FILL/REFILL, so this is a true accept
        accept = in_valid && in_ready_q;
        // Strict compare: equal scores keep the earlier (lower) index
        better = min_q ? (score_c < best_score_q) : (score_c > best_score_q);

        case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = fill_idx_q;
                    if (fill_idx_q == LAST_K) begin
                        wgt_en     = 1'b1;
                        fill_idx_d = '0;
                        k_d        = '0;
                        state_d    = EVAL;
                    end else begin
                        fill_idx_d = fill_idx_q + DOOR_W'(1);
                    end
                end
            end
            REFILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wgt_en  = 1'b1;
                    wr_idx  = out_door_q;
                    k_d     = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if ((k_q == '0) || better) begin
                    best_idx_d   = k_q;
                    best_score_d = score_c;
                end
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + DOOR_W'(1);
                end
            end
            OUT: begin
                // First OUT cycle publishes the settled best; then wait for handshake
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_door_d  = best_idx_q;
                    out_id_d    = slot_id_q[best_idx_q];
                    out_score_d = best_score_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = (cnt_d == CNT_MAX) ? DONE : REFILL;
                end
            end
            DONE: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (wr_en) begin
            slot_id_d[wr_idx]   = in_id;
            slot_size_d[wr_idx] = in_size;
            slot_iq_d[wr_idx]   = in_iq;
            slot_eq_d[wr_idx]   = in_eq;
        end
        if (wgt_en) begin
            wsize_d = in_wsize;
            wiq_d   = in_wiq;
            weq_d   = in_weq;
            min_d   = in_min;
        end

        // Registered ready drops on the accepting edge itself
        in_ready_d = (state_d == FILL) || (state_d == REFILL);
        done_d     = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            slot_id_q    <= '{default: '0};
            slot_size_q  <= '{default: '0};
            slot_iq_q    <= '{default: '0};
            slot_eq_q    <= '{default: '0};
            wsize_q      <= '0;
            wiq_q        <= '0;
            weq_q        <= '0;
            min_q        <= 1'b0;
            fill_idx_q   <= '0;
            k_q          <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_door_q   <= '0;
            out_id_q     <= '0;
            out_score_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_id_q    <= slot_id_d;
            slot_size_q  <= slot_size_d;
            slot_iq_q    <= slot_iq_d;
            slot_eq_q    <= slot_eq_d;
            wsize_q      <= wsize_d;
            wiq_q        <= wiq_d;
            weq_q        <= weq_d;
            min_q        <= min_d;
            fill_idx_q   <= fill_idx_d;
            k_q          <= k_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_door_q   <= out_door_d;
            out_id_q     <= out_id_d;
            out_score_q  <= out_score_d;
            done_q       <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_door  = out_door_q;
    assign out_id    = out_id_q;
    assign out_score = out_score_q;
    assign done      = done_q;

endmodule

// File: tb/tb_doraemon_selector.sv
// ---------------------------------------------------------------------------
// tb_doraemon_selector
// Scoreboard bench: expected selections are queued when the last record of a
// fill/refill is driven and compared when the result handshake happens.
// A second instance with TOTAL=3 exercises the selection quota.
// ---------------------------------------------------------------------------
module tb_doraemon_selector;
    import doraemon_pkg::*;

    localparam int unsigned N_DOOR  = 5;
    localparam int unsigned ID_W    = DEF_ID_W;
    localparam int unsigned ATTR_W  = DEF_ATTR_W;
    localparam int unsigned WGT_W   = DEF_WGT_W;
    localparam int unsigned SCORE_W = score_w(ATTR_W, WGT_W);
    localparam int unsigned DOOR_W  = $clog2(N_DOOR);
    localparam int unsigned LAT     = N_DOOR + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main DUT signals
    logic               in_valid, in_ready, in_min;
    logic [ID_W-1:0]    in_id;
    logic [ATTR_W-1:0]  in_size, in_iq, in_eq;
    logic [WGT_W-1:0]   in_wsize, in_wiq, in_weq;
    logic               out_valid, out_ready, done;
    logic [DOOR_W-1:0]  out_door;
    logic [ID_W-1:0]    out_id;
    logic [SCORE_W-1:0] out_score;

    // Quota DUT signals
    logic               q_in_valid, q_in_ready, q_in_min;
    logic [ID_W-1:0]    q_in_id;
    logic [ATTR_W-1:0]  q_in_size, q_in_iq, q_in_eq;
    logic [WGT_W-1:0]   q_in_wsize, q_in_wiq, q_in_weq;
    logic               q_out_valid, q_out_ready, q_done;
    logic [DOOR_W-1:0]  q_out_door;
    logic [ID_W-1:0]    q_out_id;
    logic [SCORE_W-1:0] q_out_score;

    doraemon_selector #(
        .N_DOOR(N_DOOR), .ID_W(ID_W), .ATTR_W(ATTR_W), .WGT_W(WGT_W), .TOTAL(6000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_size(in_size), .in_iq(in_iq), .in_eq(in_eq),
        .in_wsize(in_wsize), .in_wiq(in_wiq), .in_weq(in_weq), .in_min(in_min),
        .out_valid(out_valid), .out_ready(out_ready), .out_door(out_door),
        .out_id(out_id), .out_score(out_score), .done(done)
    );

    doraemon_selector #(
        .N_DOOR(N_DOOR), .ID_W(ID_W), .ATTR_W(ATTR_W), .WGT_W(WGT_W), .TOTAL(3)
    ) dut_q (
        .clk(clk), .rst_n(rst_n),
        .in_valid(q_in_valid), .in_ready(q_in_ready), .in_id(q_in_id),
        .in_size(q_in_size), .in_iq(q_in_iq), .in_eq(q_in_eq),
        .in_wsize(q_in_wsize), .in_wiq(q_in_wiq), .in_weq(q_in_weq), .in_min(q_in_min),
        .out_valid(q_out_valid), .out_ready(q_out_ready), .out_door(q_out_door),
        .out_id(q_out_id), .out_score(q_out_score), .done(q_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] door;
        logic [31:0] id;
        logic [31:0] score;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input int d, input int id, input int s);
        exp_t e;
        e.door  = 32'(d);
        e.id    = 32'(id);
        e.score = 32'(s);
        sb.push_back(e);
    endtask

    // Result monitor: handshake seen at negedge completes on the next posedge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("out_door",  32'(out_door),  mon_e.door);
                check_eq("out_id",    32'(out_id),    mon_e.id);
                check_eq("out_score", 32'(out_score), mon_e.score);
            end
        end
    end

    // Quota DUT observation
    int q_hs = 0, q_acc = 0, q_hs1 = 0, q_hs2 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (q_out_valid && q_out_ready) begin
                q_hs++;
                if (q_hs == 1) q_hs1 = cyc;
                else if (q_hs == 2) q_hs2 = cyc;
            end
            if (q_in_valid && q_in_ready) q_acc++;
        end
    end

    task automatic chk_reset(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_done"},      32'(done),      32'd0);
        check_eq({tag, "_out_door"},  32'(out_door),  32'd0);
        check_eq({tag, "_out_id"},    32'(out_id),    32'd0);
        check_eq({tag, "_out_score"}, 32'(out_score), 32'd0);
    endtask

    // Drive one record and hold it until an accepting edge (bounded)
    task automatic send(input rec_t r, input logic [WGT_W-1:0] ws, input logic [WGT_W-1:0] wi,
                        input logic [WGT_W-1:0] we, input logic mn);
        int n = 0;
        in_valid = 1'b1;
        in_id    = r.id;
        in_size  = r.size;
        in_iq    = r.iq;
        in_eq    = r.eq;
        in_wsize = ws;
        in_wiq   = wi;
        in_weq   = we;
        in_min   = mn;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(LAT));
    endtask

    task automatic drain(input logic exp_ir);
        out_ready = 1'b1;
        check_eq("drain_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("ov_fall", 32'(out_valid), 32'd0);
        check_eq("ir_after_hs", 32'(in_ready), 32'(exp_ir));
    endtask

    task automatic fill_ramp();
        rec_t r;
        for (int i = 0; i < 5; i++) begin
            r.id   = ID_W'(i + 1);
            r.size = ATTR_W'(10 * (i + 1));
            r.iq   = '0;
            r.eq   = '0;
            send(r, 3'd1, 3'd0, 3'd0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        int   prev_acc;
        int   ov_seen;
        int   ir_seen;

        rst_n = 1'b0;
        in_valid = 1'b0; in_id = '0; in_size = '0; in_iq = '0; in_eq = '0;
        in_wsize = '0; in_wiq = '0; in_weq = '0; in_min = 1'b0; out_ready = 1'b0;
        q_in_valid = 1'b0; q_in_id = '0; q_in_size = '0; q_in_iq = '0; q_in_eq = '0;
        q_in_wsize = '0; q_in_wiq = '0; q_in_weq = '0; q_in_min = 1'b0; q_out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst0");
        check_eq("q_done_rst", 32'(q_done), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("ir_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("ir_first_edge", 32'(in_ready), 32'd1);

        // Max mode ramp
        fill_ramp();
        check_eq("ir_fall_fill", 32'(in_ready), 32'd0);
        push_exp(4, 5, 50);
        wait_valid("t1");

        // Backpressure with junk input offered: everything must hold
        in_valid = 1'b1; in_id = 5'd31; in_size = 8'd255; in_iq = 8'd255; in_eq = 8'd255;
        in_wsize = 3'd7; in_wiq = 3'd7; in_weq = 3'd7; in_min = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", 32'({out_valid, in_ready, out_door, out_id, out_score}),
                     32'({1'b1, 1'b0, 3'd4, 5'd5, 13'd50}));
        end
        in_valid = 1'b0;
        drain(1'b1);

        // Refill winner slot, min mode
        r = '{id: 5'd9, size: 8'd0, iq: 8'd0, eq: 8'd0};
        send(r, 3'd1, 3'd0, 3'd0, 1'b1);
        prev_acc = acc_cyc;
        push_exp(4, 9, 0);
        wait_valid("t2");
        drain(1'b1);

        // Back to max mode; back-to-back refill gives the throughput bound
        r.size = 8'd60;
        send(r, 3'd1, 3'd0, 3'd0, 1'b0);
        check_eq("throughput", 32'(acc_cyc - prev_acc), 32'(N_DOOR + 3));
        push_exp(4, 9, 60);
        wait_valid("t3");
        drain(1'b1);

        // Async reset with non-zero result registers
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie: equal scores go to the lowest index
        for (int i = 0; i < 5; i++) begin
            r = '{id: ID_W'(11 + i), size: 8'd100, iq: 8'd100, eq: 8'd100};
            send(r, 3'd7, 3'd7, 3'd7, 1'b0);
        end
        push_exp(0, 11, 2100);
        wait_valid("t4");
        drain(1'b1);
        r = '{id: 5'd9, size: 8'd255, iq: 8'd255, eq: 8'd255};
        send(r, 3'd7, 3'd7, 3'd7, 1'b0);
        push_exp(0, 9, 5355);
        wait_valid("t5");
        drain(1'b1);
        // Min-mode tie across all slots
        r = '{id: 5'd20, size: 8'd100, iq: 8'd100, eq: 8'd100};
        send(r, 3'd7, 3'd7, 3'd7, 1'b1);
        push_exp(0, 20, 2100);
        wait_valid("t6");
        drain(1'b1);

        // Reset in the middle of EVAL (k=2)
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_ramp();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_eval");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check_eq("no_partial_result", 32'(ov_seen), 32'd0);
        check_eq("ir_after_eval_rst", 32'(in_ready), 32'd1);
        fill_ramp();
        push_exp(4, 5, 50);
        wait_valid("t7");
        drain(1'b1);

        // Quota on the TOTAL=3 instance with continuous traffic
        q_in_valid = 1'b1; q_out_ready = 1'b1;
        q_in_id = 5'd3; q_in_size = 8'd5; q_in_iq = 8'd1; q_in_eq = 8'd2;
        q_in_wsize = 3'd1; q_in_wiq = 3'd1; q_in_weq = 3'd1; q_in_min = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        ir_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (q_in_ready || q_out_valid || !q_done) ir_seen++;
        end
        check_eq("q_handshakes", 32'(q_hs), 32'd3);
        check_eq("q_accepts", 32'(q_acc), 32'd7);
        check_eq("q_gap", 32'(q_hs2 - q_hs1), 32'(N_DOOR + 3));
        check_eq("q_done", 32'(q_done), 32'd1);
        check_eq("q_in_ready", 32'(q_in_ready), 32'd0);
        check_eq("q_done_hold", 32'(ir_seen), 32'd0);
        check_eq("q_score", 32'(q_out_score), 32'd8);
        q_in_valid = 1'b0;

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
